// File: rtl/r_fifo_pkt_pkg.sv
// Shared types, width helper and elaboration-time parameter checks for the R-channel FIFO.
// The check macro is global so the top module can guard its parameters.
`ifndef R_FIFO_PKG_SV
`define R_FIFO_PKG_SV

`define R_FIFO_ELAB_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package r_fifo_pkg;

    localparam int DEF_ID_WIDTH   = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int RESP_WIDTH     = 2;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0]     resp;
        logic                      last;
    } r_beat_t;

    // Pointer/count width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`endif

// File: rtl/r_fifo_pkt_if.sv
// R-channel FIFO bus: write-side beat, pop request, status flags and head beat.
interface r_fifo_pkt_if
    import r_fifo_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int CW = ptr_w(DEPTH);

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [CW-1:0]         count;
    logic [CW-1:0]         pkt_count;
    logic [ID_WIDTH-1:0]   front_RID;
    logic [DATA_WIDTH-1:0] front_RDATA;
    logic [1:0]            front_RRESP;
    logic                  front_RLAST;

    // push/pop are requests; a request is accepted on a rising edge only when
    // full (for push) or empty (for pop) was low before that edge. Rejected
    // requests are silently dropped; the producer must hold them to retry.
    modport slave (
        input  RID, RDATA, RRESP, RLAST, push, pop,
        output full, empty, almost_full, count, pkt_count,
               front_RID, front_RDATA, front_RRESP, front_RLAST
    );

    modport master (
        output RID, RDATA, RRESP, RLAST, push, pop,
        input  full, empty, almost_full, count, pkt_count,
               front_RID, front_RDATA, front_RRESP, front_RLAST
    );
endinterface

// File: rtl/r_fifo_pkt_sync_fifo_core.sv
// Generic single-clock FWFT storage: pointers with wrap bit, occupancy count and full.
// Enables arrive already qualified by the wrapper; the core never sees a rejected request.
module sync_fifo_core
    import r_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    count,
    output logic             full
);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == PW'(DEPTH));
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/r_fifo_pkt.sv
// AXI R-channel FIFO with occupancy, almost-full and optional whole-burst release.
// In packet mode the head is hidden until an RLAST beat is stored, unless the FIFO is full.
module r_fifo_pkt
    import r_fifo_pkg::*;
#(
    parameter int ID_WIDTH     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int PKT_MODE     = 0,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input logic        clk,
    input logic        nrst,
    r_fifo_pkt_if.slave bus
);
    localparam int CW = ptr_w(DEPTH);

    `R_FIFO_ELAB_CHECK(g_chk_depth, is_pow2(DEPTH) && (DEPTH >= 2), "r_fifo_pkt: DEPTH must be a power of two >= 2")
    `R_FIFO_ELAB_CHECK(g_chk_afull, (AFULL_THRESH >= 1) && (AFULL_THRESH <= DEPTH), "r_fifo_pkt: AFULL_THRESH must be in 1..DEPTH")
    `R_FIFO_ELAB_CHECK(g_chk_mode, (PKT_MODE == 0) || (PKT_MODE == 1), "r_fifo_pkt: PKT_MODE must be 0 or 1")

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

    localparam int BW = $bits(beat_t);

    beat_t         wr_beat;
    beat_t         head;
    logic [CW-1:0] count;
    logic [CW-1:0] pkt_count;
    logic          full;
    logic          empty;
    logic          push_acc;
    logic          pop_acc;
    logic          pkt_inc;
    logic          pkt_dec;

    assign wr_beat = '{id: bus.RID, data: bus.RDATA, resp: bus.RRESP, last: bus.RLAST};

    // full and empty come from registered state only, so acceptance has no loop.
    assign push_acc = bus.push & ~full;
    assign pop_acc  = bus.pop & ~empty;

    sync_fifo_core #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk),
        .nrst    (nrst),
        .wr_en   (push_acc),
        .rd_en   (pop_acc),
        .wr_data (wr_beat),
        .rd_data (head),
        .count   (count),
        .full    (full)
    );

    assign pkt_inc = push_acc & wr_beat.last;
    assign pkt_dec = pop_acc & head.last;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pkt_count <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // A burst longer than DEPTH never stores RLAST; full releases it to avoid deadlock.
    generate
        if (PKT_MODE != 0) begin : g_pkt_empty
            assign empty = (count == '0) | ((pkt_count == '0) & ~full);
        end else begin : g_plain_empty
            assign empty = (count == '0);
        end
    endgenerate

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count >= CW'(AFULL_THRESH));
    assign bus.count       = count;
    assign bus.pkt_count   = pkt_count;

    // Storage is unreset, so the head is masked whenever nothing is stored.
    always_comb begin
        bus.front_RID   = '0;
        bus.front_RDATA = '0;
        bus.front_RRESP = '0;
        bus.front_RLAST = 1'b0;
        if (count != '0) begin
            bus.front_RID   = head.id;
            bus.front_RDATA = head.data;
            bus.front_RRESP = head.resp;
            bus.front_RLAST = head.last;
        end
    end

endmodule

// File: tb/tb_r_fifo_pkt.sv
// Scoreboard bench for r_fifo_pkt: one plain-FWFT instance and one packet-mode instance.
// Drivers queue expected beats; a negedge monitor checks every accepted pop.
module tb_r_fifo_pkt;
  import r_fifo_pkg::*;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int W   = IDW + DW + 2 + 1;

  logic clk;
  logic nrst;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q_plain[$];
  logic [W-1:0] exp_q_pkt[$];

  r_fifo_pkt_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEPTH(DEP)) if_plain ();
  r_fifo_pkt_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEPTH(DEP)) if_pkt ();

  r_fifo_pkt #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEPTH(DEP), .PKT_MODE(0), .AFULL_THRESH(6)
  ) u_plain (
    .clk  (clk),
    .nrst (nrst),
    .bus  (if_plain)
  );

  r_fifo_pkt #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEPTH(DEP), .PKT_MODE(1), .AFULL_THRESH(6)
  ) u_pkt (
    .clk  (clk),
    .nrst (nrst),
    .bus  (if_pkt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_beat(input logic [IDW-1:0] id, input logic [DW-1:0] data,
                                           input logic [1:0] resp, input logic last);
    return {id, data, resp, last};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: one call = one clock of stimulus, applied #1 after the rising edge
  task automatic step(input bit sel, input bit do_push, input bit do_pop,
                      input logic [W-1:0] beat, input bit exp_acc);
    @(posedge clk);
    #1;
    if_plain.push = 1'b0; if_plain.pop = 1'b0;
    if_pkt.push   = 1'b0; if_pkt.pop   = 1'b0;
    if (sel == 1'b0) begin
      {if_plain.RID, if_plain.RDATA, if_plain.RRESP, if_plain.RLAST} = beat;
      if_plain.push = do_push;
      if_plain.pop  = do_pop;
      if (do_push && exp_acc) exp_q_plain.push_back(beat);
    end else begin
      {if_pkt.RID, if_pkt.RDATA, if_pkt.RRESP, if_pkt.RLAST} = beat;
      if_pkt.push = do_push;
      if_pkt.pop  = do_pop;
      if (do_push && exp_acc) exp_q_pkt.push_back(beat);
    end
  endtask

  task automatic idle(input bit sel);
    step(sel, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // scoreboard monitor: compares the head on every cycle a pop will be accepted
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (nrst && if_plain.pop && !if_plain.empty) begin
        act = {if_plain.front_RID, if_plain.front_RDATA, if_plain.front_RRESP, if_plain.front_RLAST};
        exp = (exp_q_plain.size() > 0) ? exp_q_plain.pop_front() : '1;
        check("pop_plain", act, exp);
      end
      if (nrst && if_pkt.pop && !if_pkt.empty) begin
        act = {if_pkt.front_RID, if_pkt.front_RDATA, if_pkt.front_RRESP, if_pkt.front_RLAST};
        exp = (exp_q_pkt.size() > 0) ? exp_q_pkt.pop_front() : '1;
        check("pop_pkt", act, exp);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    if_plain.push = 1'b0; if_plain.pop = 1'b0;
    if_plain.RID = '0; if_plain.RDATA = '0; if_plain.RRESP = '0; if_plain.RLAST = 1'b0;
    if_pkt.push = 1'b0; if_pkt.pop = 1'b0;
    if_pkt.RID = '0; if_pkt.RDATA = '0; if_pkt.RRESP = '0; if_pkt.RLAST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_plain_empty", if_plain.empty, 1);
    check("rst_plain_full", if_plain.full, 0);
    check("rst_plain_count", if_plain.count, 0);
    check("rst_pkt_empty", if_pkt.empty, 1);
    check("rst_pkt_afull", if_pkt.almost_full, 0);
    check("rst_pkt_front", {if_pkt.front_RID, if_pkt.front_RDATA, if_pkt.front_RRESP, if_pkt.front_RLAST}, 0);
    nrst = 1'b1;

    // 1: fill plain FIFO, reject 9th push, drain in order
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, mk_beat(4'(i), 32'h10 + 32'(i), 2'(i % 4), (i == 7)), 1);
    step(0, 1, 0, mk_beat(4'hF, 32'h99, 2'b11, 1'b1), 0);
    check("t1_full", if_plain.full, 1);
    check("t1_count8", if_plain.count, 8);
    check("t1_afull", if_plain.almost_full, 1);
    check("t1_pkt_count", if_plain.pkt_count, 1);
    idle(0);
    check("t1_count_after_reject", if_plain.count, 8);
    check("t1_head", if_plain.front_RDATA, 32'h10);
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0, 0);
    idle(0);
    check("t1_empty", if_plain.empty, 1);
    check("t1_count0", if_plain.count, 0);
    check("t1_front_zero", {if_plain.front_RID, if_plain.front_RDATA, if_plain.front_RRESP, if_plain.front_RLAST}, 0);

    // 4: push+pop on empty stores; push+pop on full pops and drops the push
    step(0, 1, 1, mk_beat(4'h3, 32'hA5A5_0001, 2'b01, 1'b1), 1);
    idle(0);
    check("t4_empty_pp_count", if_plain.count, 1);
    check("t4_empty_pp_head", if_plain.front_RDATA, 32'hA5A5_0001);
    step(0, 0, 1, '0, 0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, mk_beat(4'(i + 1), 32'h20 + 32'(i), 2'b00, 1'b0), 1);
    step(0, 1, 1, mk_beat(4'h7, 32'h55, 2'b00, 1'b0), 0);
    check("t4_full_before", if_plain.full, 1);
    idle(0);
    check("t4_full_pp_count", if_plain.count, 7);
    check("t4_full_pp_full", if_plain.full, 0);
    check("t4_full_pp_head", if_plain.front_RDATA, 32'h21);
    for (int i = 0; i < 7; i++) step(0, 0, 1, '0, 0);
    idle(0);
    check("t4_empty", if_plain.empty, 1);

    // 5: steady push+pop at count 4 across pointer wrap, then almost_full threshold
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, mk_beat(4'(i), 32'h30 + 32'(i), 2'b10, 1'b0), 1);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, mk_beat(4'(i), 32'h40 + 32'(i), 2'(i % 4), 1'(i % 3 == 0)), 1);
      if (i == 20) check("t5_count_mid", if_plain.count, 4);
    end
    idle(0);
    check("t5_count4", if_plain.count, 4);
    check("t5_afull0", if_plain.almost_full, 0);
    step(0, 1, 0, mk_beat(4'hA, 32'h90, 2'b00, 1'b0), 1);
    step(0, 1, 0, mk_beat(4'hB, 32'h91, 2'b00, 1'b0), 1);
    check("t5_count5", if_plain.count, 5);
    check("t5_afull_at5", if_plain.almost_full, 0);
    idle(0);
    check("t5_count6", if_plain.count, 6);
    check("t5_afull_at6", if_plain.almost_full, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, '0, 0);
    idle(0);
    check("t5_empty", if_plain.empty, 1);

    // 2: packet mode hides a partial burst until RLAST is stored
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, mk_beat(4'h5, 32'h50 + 32'(i), 2'b00, 1'b0), 1);
    idle(1);
    check("t2_empty_partial", if_pkt.empty, 1);
    check("t2_count3", if_pkt.count, 3);
    check("t2_pkt0", if_pkt.pkt_count, 0);
    step(1, 0, 1, '0, 0);
    step(1, 1, 0, mk_beat(4'h5, 32'h53, 2'b00, 1'b1), 1);
    check("t2_pop_ignored", if_pkt.count, 3);
    idle(1);
    check("t2_released", if_pkt.empty, 0);
    check("t2_pkt1", if_pkt.pkt_count, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, '0, 0);
    idle(1);
    check("t2_empty_end", if_pkt.empty, 1);
    check("t2_pkt_end", if_pkt.pkt_count, 0);

    // 3: 12-beat burst overflows DEPTH; full releases it beat by beat
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, mk_beat(4'h9, 32'h60 + 32'(i), 2'b00, 1'b0), 1);
    idle(1);
    check("t3_full", if_pkt.full, 1);
    check("t3_full_releases", if_pkt.empty, 0);
    check("t3_pkt0", if_pkt.pkt_count, 0);
    for (int k = 8; k < 12; k++) begin
      step(1, 0, 1, '0, 0);
      if (k > 8) check("t3_refull", if_pkt.full, 1);
      step(1, 1, 0, mk_beat(4'h9, 32'h60 + 32'(k), 2'b00, (k == 11)), 1);
      check("t3_gap_count", if_pkt.count, 7);
      check("t3_gap_empty", if_pkt.empty, 1);
    end
    step(1, 0, 1, '0, 0);
    check("t3_tail_count", if_pkt.count, 8);
    check("t3_tail_pkt", if_pkt.pkt_count, 1);
    check("t3_tail_empty", if_pkt.empty, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, '0, 0);
    idle(1);
    check("t3_drained", if_pkt.count, 0);
    check("t3_pkt_end", if_pkt.pkt_count, 0);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, mk_beat(4'h2, 32'h70 + 32'(i), 2'b00, (i == 2)), 1);
    idle(1);
    check("t6_count5", if_pkt.count, 5);
    check("t6_pkt1", if_pkt.pkt_count, 1);
    #3;
    nrst = 1'b0;
    #1;
    check("t6_rst_count", if_pkt.count, 0);
    check("t6_rst_pkt", if_pkt.pkt_count, 0);
    check("t6_rst_empty", if_pkt.empty, 1);
    check("t6_rst_full", if_pkt.full, 0);
    check("t6_rst_front", {if_pkt.front_RID, if_pkt.front_RDATA, if_pkt.front_RRESP, if_pkt.front_RLAST}, 0);
    exp_q_pkt.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    step(1, 1, 0, mk_beat(4'hC, 32'h80, 2'b10, 1'b1), 1);
    idle(1);
    check("t6_head_after_rst", if_pkt.front_RDATA, 32'h80);
    check("t6_count1", if_pkt.count, 1);
    check("t6_not_empty", if_pkt.empty, 0);
    step(1, 0, 1, '0, 0);
    idle(1);
    check("t6_empty_end", if_pkt.empty, 1);

    check("plain_queue_drained", exp_q_plain.size(), 0);
    check("pkt_queue_drained", exp_q_pkt.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/r_fifo_pkt.md
Name: r_fifo_pkt

Overview:
- Single-clock, parametrised AXI read-data (R channel) FIFO for the XBar. It is the same-domain successor to the dual-clock R-channel FIFO.
- Adds configurable depth, occupancy count and an almost-full flag.
- Adds an optional packet mode: the consumer sees data only once a complete burst (RLAST beat) is stored.
- Sits between a slave-side R response path and the master-side R arbiter. Packet mode lets the arbiter forward whole bursts without mid-burst stalls.

Parameters:
- ID_WIDTH, 4, RID width
- DATA_WIDTH, 32, RDATA width
- DEPTH, 8, number of entries; power of two, >= 2
- PKT_MODE, 0, 0 = plain FWFT FIFO; 1 = packet mode
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH

Ports:
- clk  in  1  clock; all logic rising-edge
- nrst  in  1  reset, asynchronous assert, active-low
- RID  in  ID_WIDTH  write-side beat ID
- RDATA  in  DATA_WIDTH  write-side beat data
- RRESP  in  2  write-side beat response
- RLAST  in  1  write-side beat last flag
- push  in  1  write request
- pop  in  1  read request
- full  out  1  count == DEPTH
- empty  out  1  no poppable beat
- almost_full  out  1  count >= AFULL_THRESH
- count  out  $clog2(DEPTH)+1  stored beats, 0..DEPTH
- pkt_count  out  $clog2(DEPTH)+1  stored beats with RLAST=1
- front_RID  out  ID_WIDTH  head beat ID
- front_RDATA  out  DATA_WIDTH  head beat data
- front_RRESP  out  2  head beat response
- front_RLAST  out  1  head beat last flag

Behaviour:
- Reset (nrst=0, asynchronous):
  - wr_ptr, rd_ptr, count and pkt_count go to 0.
  - full=0, almost_full=0, empty=1, all front_* = 0.
  - Storage contents are not reset.
  - Reset mid-burst discards all stored beats, including partial bursts.
- Pointers:
  - Width is $clog2(DEPTH)+1; the MSB is the wrap bit and the lower bits index storage.
  - Each pointer increments by 1 per accepted operation and wraps naturally modulo 2*DEPTH.
- Acceptance:
  - push_acc = push & ~full. Beat {RID,RDATA,RRESP,RLAST} is written at wr_ptr on that edge.
  - pop_acc = pop & ~empty. rd_ptr advances on that edge.
  - A rejected push or pop changes no state. No error flag is raised.
- Simultaneous push and pop:
  - Full: the pop is accepted and the push is rejected, because full is evaluated before the edge.
  - Empty: the push is accepted and the pop is ignored.
  - Otherwise both are accepted and count is unchanged.
- Counters:
  - count is +1 on push only, -1 on pop only, and unchanged on both.
  - pkt_count is +1 on push_acc with RLAST=1, -1 on pop_acc with front_RLAST=1, and unchanged when both occur.
- Flags full, almost_full, count and pkt_count are registered or derived from registered state. They update the cycle after the accepting edge.
- Head output:
  - First-word fall-through: front_* shows storage[rd_ptr] combinationally from registered state.
  - A beat pushed at edge N is visible on front_* and poppable after edge N; latency is 1 cycle.
  - front_* is forced to 0 whenever count == 0.
- empty:
  - PKT_MODE=0: empty = (count == 0).
  - PKT_MODE=1: empty = (count == 0) | ((pkt_count == 0) & ~full).
- Packet-mode overflow release: a burst longer than DEPTH fills the FIFO with no RLAST stored. full then forces empty low so the burst streams out without deadlock.
- In packet mode, once the head burst is released it stays poppable until its RLAST beat leaves, because pkt_count >= 1 throughout.

Decomposition:
- Package r_fifo_pkg:
  - typedef r_beat_t, a packed struct {id, data, resp, last} parametrised via localparams.
  - Function clog2-based PTR_W helper.
  - An elaboration-time assertion macro for the power-of-two DEPTH and AFULL_THRESH range checks.
- Sub-module sync_fifo_core (generic WIDTH/DEPTH): storage, pointers, count, full and the raw front word.
- r_fifo_pkt adds the following around the core: RLAST packing, pkt_count, almost_full, empty qualification and front zero-forcing.

Test Plan:
1. Reset, then push 8 beats with RDATA=0x10..0x17 and RLAST only on the 8th, PKT_MODE=0, DEPTH=8. Expect full=1 and count=8; a 9th push is rejected; pops return 0x10..0x17 in order; then empty=1 and front_*=0.
2. PKT_MODE=1, push 3 beats with RLAST=0. Expect empty=1, count=3 and pkt_count=0. Push a 4th beat with RLAST=1: empty=0 the next cycle and pkt_count=1. Popping 4 beats returns all of them, then empty=1.
3. PKT_MODE=1, DEPTH=8, a 12-beat burst. When count reaches 8 with no RLAST, full=1 forces empty=0. Interleaved push/pop drains all 12 beats in order with no deadlock.
4. Full FIFO with push+pop asserted in the same cycle: the head pops, the push is dropped and count becomes 7. On an empty FIFO, push+pop stores the beat and count becomes 1.
5. Continuous push+pop for 40 cycles at count=4 (pointer wrap exercised). count stays 4 and data order is preserved; AFULL_THRESH=6 keeps almost_full=0. Raise occupancy to 6 and almost_full becomes 1.
6. Assert nrst low asynchronously mid-burst with count=5 and pkt_count=1. Outputs go to reset values without waiting for a clock edge. The first push after reset is returned as the head.
